// File: rtl/xor_hash_pkg.sv
// Shared definitions for the XOR hash table update controller.
package xor_hash_pkg;

    // Controller mode: INIT sweeps the table to zero, RUN serves requests.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of table entries addressed by an index of the given width.
    function automatic int unsigned depth_of(input int unsigned index_width);
        return 32'd1 << index_width;
    endfunction

endpackage

// File: rtl/xor_fwd_lane.sv
// One data lane: picks the freshest value of the addressed word and XORs the operand into it.
module xor_fwd_lane
    import xor_hash_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned DATA_WIDTH  = 64
) (
    input  logic                   en_i,
    input  logic                   zero_base_i,
    input  logic [INDEX_WIDTH-1:0] req_index_i,
    input  logic [DATA_WIDTH-1:0]  operand_i,
    input  logic                   d1_en_i,
    input  logic [INDEX_WIDTH-1:0] d1_index_i,
    input  logic [DATA_WIDTH-1:0]  d1_data_i,
    input  logic                   d2_en_i,
    input  logic [INDEX_WIDTH-1:0] d2_index_i,
    input  logic [DATA_WIDTH-1:0]  d2_data_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    output logic [DATA_WIDTH-1:0]  result_o
);

    logic [DATA_WIDTH-1:0] base;

    // Newest write wins: distance-1 over distance-2 over table read; sweep writes start from zero.
    always_comb begin
        base = mem_data_i;
        if (d2_en_i && (d2_index_i == req_index_i)) base = d2_data_i;
        if (d1_en_i && (d1_index_i == req_index_i)) base = d1_data_i;
        if (zero_base_i) base = '0;
        result_o = en_i ? (operand_i ^ base) : '0;
    end

endmodule

// File: rtl/xor_hash_update_ctrl.sv
// Read-modify-write controller for an XOR-accumulating table with a fixed 2-cycle write latency.
module xor_hash_update_ctrl
    import xor_hash_pkg::*;
#(
    parameter int unsigned NUM_MUL     = 4,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned DATA_WIDTH  = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INDEX_WIDTH-1:0]          in_index,
    input  logic [NUM_MUL-1:0]              in_mask,
    input  logic [NUM_MUL*DATA_WIDTH-1:0]   in_data,
    input  logic                            clear_req,
    output logic [INDEX_WIDTH-1:0]          rd_index,
    input  logic [NUM_MUL*DATA_WIDTH-1:0]   rd_out_update,
    output logic                            write_reg_0_valid,
    output logic [INDEX_WIDTH-1:0]          write_reg_0_index,
    output logic [NUM_MUL-1:0]              arbiter_result,
    output logic [NUM_MUL*DATA_WIDTH-1:0]   write_reg_11_xor,
    output logic [31:0]                     upd_count
);

    localparam int unsigned DEPTH = depth_of(INDEX_WIDTH);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(DEPTH - 1);
    localparam int unsigned BW = NUM_MUL * DATA_WIDTH;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;

    logic                   issue_run;
    logic [INDEX_WIDTH-1:0] issue_index;
    logic [NUM_MUL-1:0]     issue_mask;
    logic [BW-1:0]          issue_data;

    // Stage 1: request waiting for its table read data.
    logic                   s1_valid_q, s1_run_q;
    logic [INDEX_WIDTH-1:0] s1_index_q;
    logic [NUM_MUL-1:0]     s1_mask_q;
    logic [BW-1:0]          s1_data_q;

    // Stage 2: committed write on the outputs; stage 3: its one-cycle-delayed copy.
    logic [NUM_MUL-1:0]     arb_q, arb_d;
    logic [BW-1:0]          wdata_q, wdata_d;
    logic [INDEX_WIDTH-1:0] s2_index_q;
    logic [NUM_MUL-1:0]     s3_mask_q;
    logic [INDEX_WIDTH-1:0] s3_index_q;
    logic [BW-1:0]          s3_data_q;
    logic [31:0]            upd_q, upd_d;

    // Mode register and sweep counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next mode: sweep every index once, a clear request restarts the sweep from index 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (clear_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Issue stage: sweep writes and accepted requests share one pipeline.
    always_comb begin
        in_ready          = (state_q == ST_RUN) && !clear_req;
        issue_run         = (state_q == ST_RUN) && in_valid && in_ready;
        write_reg_0_valid = (state_q == ST_INIT) || issue_run;
        issue_index       = (state_q == ST_INIT) ? cnt_q : in_index;
        issue_mask        = (state_q == ST_INIT) ? '1 : in_mask;
        issue_data        = (state_q == ST_INIT) ? '0 : in_data;
        rd_index          = issue_index;
        write_reg_0_index = issue_index;
    end

    // Stage-2 inputs: lane enables and the count of committed requests.
    always_comb begin
        arb_d = s1_valid_q ? s1_mask_q : '0;
        upd_d = upd_q + 32'(s1_run_q);
    end

    for (genvar g = 0; g < NUM_MUL; g++) begin : g_lane
        xor_fwd_lane #(
            .INDEX_WIDTH (INDEX_WIDTH),
            .DATA_WIDTH  (DATA_WIDTH)
        ) u_lane (
            .en_i        (arb_d[g]),
            .zero_base_i (!s1_run_q),
            .req_index_i (s1_index_q),
            .operand_i   (s1_data_q[g*DATA_WIDTH +: DATA_WIDTH]),
            .d1_en_i     (arb_q[g]),
            .d1_index_i  (s2_index_q),
            .d1_data_i   (wdata_q[g*DATA_WIDTH +: DATA_WIDTH]),
            .d2_en_i     (s3_mask_q[g]),
            .d2_index_i  (s3_index_q),
            .d2_data_i   (s3_data_q[g*DATA_WIDTH +: DATA_WIDTH]),
            .mem_data_i  (rd_out_update[g*DATA_WIDTH +: DATA_WIDTH]),
            .result_o    (wdata_d[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Pipeline registers; reset drops everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_run_q   <= 1'b0;
            s1_index_q <= '0;
            s1_mask_q  <= '0;
            s1_data_q  <= '0;
            arb_q      <= '0;
            wdata_q    <= '0;
            s2_index_q <= '0;
            s3_mask_q  <= '0;
            s3_index_q <= '0;
            s3_data_q  <= '0;
            upd_q      <= '0;
        end else begin
            s1_valid_q <= write_reg_0_valid;
            s1_run_q   <= issue_run;
            s1_index_q <= issue_index;
            s1_mask_q  <= issue_mask;
            s1_data_q  <= issue_data;
            arb_q      <= arb_d;
            wdata_q    <= wdata_d;
            s2_index_q <= s1_index_q;
            s3_mask_q  <= arb_q;
            s3_index_q <= s2_index_q;
            s3_data_q  <= wdata_q;
            upd_q      <= upd_d;
        end
    end

    assign arbiter_result   = arb_q;
    assign write_reg_11_xor = wdata_q;
    assign upd_count        = upd_q;

endmodule

// File: tb/tb_xor_hash_update_ctrl.sv
// Bench for xor_hash_update_ctrl: table stage model plus a table-level reference of expected writes.
module tb_xor_hash_update_ctrl;

    localparam int NM    = 4;
    localparam int IW    = 12;
    localparam int DW    = 64;
    localparam int DEPTH = 4096;
    localparam int BW    = NM * DW;
    localparam int CW    = 2 + 2 * IW + 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid, in_ready, clear_req;
    logic [IW-1:0] in_index, rd_index, write_reg_0_index;
    logic [NM-1:0] in_mask, arbiter_result;
    logic [BW-1:0] in_data, rd_out_update, write_reg_11_xor;
    logic          write_reg_0_valid;
    logic [31:0]   upd_count;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    xor_hash_update_ctrl #(
        .NUM_MUL     (NM),
        .INDEX_WIDTH (IW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_index          (in_index),
        .in_mask           (in_mask),
        .in_data           (in_data),
        .clear_req         (clear_req),
        .rd_index          (rd_index),
        .rd_out_update     (rd_out_update),
        .write_reg_0_valid (write_reg_0_valid),
        .write_reg_0_index (write_reg_0_index),
        .arbiter_result    (arbiter_result),
        .write_reg_11_xor  (write_reg_11_xor),
        .upd_count         (upd_count)
    );

    always #5 clk = ~clk;

    // Table stage: registered read of rd_index, lane writes applied two cycles after issue.
    logic [BW-1:0] env_mem [DEPTH];
    logic [IW-1:0] idx_p1, idx_p2;
    always @(posedge clk) begin
        rd_out_update <= env_mem[rd_index];
        for (int l = 0; l < NM; l++)
            if (arbiter_result[l]) env_mem[idx_p2][l*DW +: DW] = write_reg_11_xor[l*DW +: DW];
        idx_p1 <= write_reg_0_index;
        idx_p2 <= idx_p1;
    end

    // Reference: table contents at request level and the writes expected 1 and 2 cycles out.
    typedef struct packed {
        logic          v;
        logic          run;
        logic [NM-1:0] m;
        logic [BW-1:0] d;
    } ex_t;

    logic [BW-1:0] ref_tab [DEPTH];
    ex_t           d1, d2;
    bit            m_init;
    int unsigned   m_cnt;
    logic [31:0]   m_upd;
    logic [CW-1:0] exp_ctrl, obs_ctrl;
    logic [NM+BW-1:0] exp_dat, obs_dat;

    function automatic logic [BW-1:0] rnd_data();
        logic [BW-1:0] r;
        for (int w = 0; w < BW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock cycle: drive inputs, predict outputs, capture observations at the falling edge.
    task automatic cyc(input logic v, input logic [IW-1:0] idx, input logic [NM-1:0] m,
                       input logic [BW-1:0] d, input logic clr);
        ex_t           ne;
        logic          e_ready, e_wv;
        logic [IW-1:0] e_idx;
        in_valid  = v;
        in_index  = idx;
        in_mask   = m;
        in_data   = d;
        clear_req = clr;
        ne = '0;
        e_ready = !m_init && !clr;
        if (d2.v && d2.run) m_upd = m_upd + 1;
        if (m_init) begin
            e_wv  = 1'b1;
            e_idx = IW'(m_cnt);
            ref_tab[m_cnt] = '0;
            ne.v = 1'b1;
            ne.m = '1;
            if (clr) m_cnt = 0;
            else if (m_cnt == DEPTH - 1) begin m_init = 0; m_cnt = 0; end
            else m_cnt++;
        end else begin
            e_wv  = v && !clr;
            e_idx = idx;
            if (clr) begin
                m_init = 1;
                m_cnt  = 0;
            end else if (v) begin
                ne.v = 1'b1;
                ne.run = 1'b1;
                ne.m = m;
                for (int l = 0; l < NM; l++) begin
                    if (m[l]) begin
                        ref_tab[idx][l*DW +: DW] = ref_tab[idx][l*DW +: DW] ^ d[l*DW +: DW];
                        ne.d[l*DW +: DW] = ref_tab[idx][l*DW +: DW];
                    end
                end
            end
        end
        exp_ctrl = {e_ready, e_wv, (e_wv ? e_idx : {IW{1'b0}}), e_idx, m_upd};
        exp_dat  = d2.v ? {d2.m, d2.d} : {(NM+BW){1'b0}};
        @(negedge clk);
        obs_ctrl = {in_ready, write_reg_0_valid, (e_wv ? write_reg_0_index : {IW{1'b0}}), rd_index, upd_count};
        obs_dat  = {arbiter_result, write_reg_11_xor};
        @(posedge clk);
        #1;
        d2 = d1;
        d1 = ne;
        cyc_n++;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, IW'($urandom), NM'($urandom), rnd_data(), 1'b0);
    endtask

    task automatic test_reset();
        in_valid = 0; in_index = '0; in_mask = '0; in_data = '0; clear_req = 0;
        #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({in_ready, arbiter_result, write_reg_11_xor, upd_count} !== '0) begin
                bad++;
                $display("FAIL reset_outputs got=%h want=0", {in_ready, arbiter_result, write_reg_11_xor, upd_count});
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        m_init = 1; m_cnt = 0; m_upd = '0; d1 = '0; d2 = '0;
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'($urandom), IW'($urandom), NM'($urandom), rnd_data(), 1'b0);
            total++;
            if (obs_ctrl !== exp_ctrl) begin bad++; $display("FAIL init_ctrl cyc=%0d got=%h want=%h", cyc_n, obs_ctrl, exp_ctrl); end
            total++;
            if (obs_dat !== exp_dat) begin bad++; $display("FAIL init_data cyc=%0d got=%h want=%h", cyc_n, obs_dat, exp_dat); end
        end
        idle_cyc();
        total++;
        if (obs_ctrl[CW-1] !== 1'b1) begin bad++; $display("FAIL init_ready_after got=%b want=1", obs_ctrl[CW-1]); end
    endtask

    task automatic test_single();
        logic [BW-1:0] want;
        want = '0;
        want[63:0] = 64'hA5;
        cyc(1'b1, 12'd5, 4'b0001, {{(BW-64){1'b1}}, 64'hA5}, 1'b0);
        idle_cyc();
        idle_cyc();
        total++;
        if (obs_dat !== {4'b0001, want}) begin bad++; $display("FAIL single_data got=%h want=%h", obs_dat, {4'b0001, want}); end
        total++;
        if (obs_ctrl[31:0] !== 32'd1) begin bad++; $display("FAIL single_count got=%0d want=1", obs_ctrl[31:0]); end
        total++;
        if (obs_dat !== exp_dat) begin bad++; $display("FAIL single_model got=%h want=%h", obs_dat, exp_dat); end
    endtask

    task automatic test_fwd1();
        cyc(1'b1, 12'd7, 4'hF, {4{64'h1}}, 1'b0);
        cyc(1'b1, 12'd7, 4'hF, {4{64'h2}}, 1'b0);
        idle_cyc();
        total++;
        if (obs_dat !== {4'hF, {4{64'h1}}}) begin bad++; $display("FAIL fwd1_first got=%h want=%h", obs_dat, {4'hF, {4{64'h1}}}); end
        idle_cyc();
        total++;
        if (obs_dat !== {4'hF, {4{64'h3}}}) begin bad++; $display("FAIL fwd1_second got=%h want=%h", obs_dat, {4'hF, {4{64'h3}}}); end
    endtask

    task automatic test_fwd2();
        cyc(1'b1, 12'd9, 4'b0011, {4{64'hF0}}, 1'b0);
        idle_cyc();
        cyc(1'b1, 12'd9, 4'b0110, {4{64'h0F}}, 1'b0);
        idle_cyc();
        idle_cyc();
        total++;
        if (obs_dat !== {4'b0110, 64'h0, 64'h0F, 64'hFF, 64'h0}) begin
            bad++;
            $display("FAIL fwd2_data got=%h want=%h", obs_dat, {4'b0110, 64'h0, 64'h0F, 64'hFF, 64'h0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < 75, IW'($urandom_range(16, 21)), NM'($urandom), rnd_data(), 1'b0);
            total++;
            if (obs_ctrl !== exp_ctrl) begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%h want=%h", cyc_n, obs_ctrl, exp_ctrl); end
            total++;
            if (obs_dat !== exp_dat) begin bad++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc_n, obs_dat, exp_dat); end
        end
    endtask

    task automatic test_clear();
        repeat (5) cyc(1'b1, IW'($urandom_range(0, 7)), NM'($urandom), rnd_data(), 1'b0);
        cyc(1'b1, 12'd5, 4'hF, rnd_data(), 1'b1);
        total++;
        if (obs_ctrl[CW-1] !== 1'b0) begin bad++; $display("FAIL clear_ready got=%b want=0", obs_ctrl[CW-1]); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cyc(1'($urandom), IW'($urandom), NM'($urandom), rnd_data(), 1'b0);
            total++;
            if (obs_ctrl !== exp_ctrl) begin bad++; $display("FAIL clear_ctrl cyc=%0d got=%h want=%h", cyc_n, obs_ctrl, exp_ctrl); end
            total++;
            if (obs_dat !== exp_dat) begin bad++; $display("FAIL clear_data cyc=%0d got=%h want=%h", cyc_n, obs_dat, exp_dat); end
        end
        cyc(1'b1, 12'd5, 4'hF, '0, 1'b0);
        idle_cyc();
        idle_cyc();
        total++;
        if (obs_dat !== {4'hF, {BW{1'b0}}}) begin bad++; $display("FAIL clear_read5 got=%h want=%h", obs_dat, {4'hF, {BW{1'b0}}}); end
    endtask

    task automatic test_reset_mid_init();
        cyc(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 1000; i++) idle_cyc();
        reset = 1'b0;
        #1;
        total++;
        if ({in_ready, arbiter_result, write_reg_11_xor, upd_count} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=0", {in_ready, arbiter_result, write_reg_11_xor, upd_count});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        m_init = 1; m_cnt = 0; m_upd = '0; d1 = '0; d2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idle_cyc();
            total++;
            if (obs_ctrl !== exp_ctrl) begin bad++; $display("FAIL reinit_ctrl cyc=%0d got=%h want=%h", cyc_n, obs_ctrl, exp_ctrl); end
            total++;
            if (obs_dat !== exp_dat) begin bad++; $display("FAIL reinit_data cyc=%0d got=%h want=%h", cyc_n, obs_dat, exp_dat); end
        end
        idle_cyc();
        total++;
        if (obs_ctrl[CW-1] !== 1'b1) begin bad++; $display("FAIL reinit_ready_after got=%b want=1", obs_ctrl[CW-1]); end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_single();
        test_fwd1();
        test_fwd2();
        test_random();
        test_clear();
        test_reset_mid_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_hash_update_ctrl.md
XOR_HASH_UPDATE_CTRL -- requirements
Module: xor_hash_update_ctrl

Interface
REQ-001 SHALL have parameter NUM_MUL, default 4, number of lanes.
REQ-002 SHALL have parameter INDEX_WIDTH, default 12, table address width (DEPTH = 2^INDEX_WIDTH).
REQ-003 SHALL have parameter DATA_WIDTH, default 64, per-lane word width.
REQ-004 SHALL have ports, one per line, clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  update request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_index  in  INDEX_WIDTH  table address of request.
- in_mask  in  NUM_MUL  per-lane write enable of request.
- in_data  in  NUM_MUL*DATA_WIDTH  per-lane XOR operand.
- clear_req  in  1  pulse; re-zero whole table.
- rd_index  out  INDEX_WIDTH  read address to table stage.
- rd_out_update  in  NUM_MUL*DATA_WIDTH  table read data, one cycle after rd_index.
- write_reg_0_valid  out  1  write issued this cycle.
- write_reg_0_index  out  INDEX_WIDTH  write address issued this cycle.
- arbiter_result  out  NUM_MUL  per-lane write enable, aligned with write_reg_11_xor.
- write_reg_11_xor  out  NUM_MUL*DATA_WIDTH  write data.
- upd_count  out  32  committed RUN updates.

Function
REQ-005 SHALL have states INIT and RUN; in_ready = (state == RUN) and clear_req == 0.
REQ-006 On accept at cycle T: rd_index, write_reg_0_index = in_index and write_reg_0_valid = 1 combinationally in cycle T.
REQ-007 rd_out_update for request at T SHALL be sampled in T+1; arbiter_result and write_reg_11_xor SHALL be registered and valid during T+2 (fixed latency 2).
REQ-008 Per lane i with mask bit set: write_reg_11_xor lane i = in_data lane i XOR current lane value; lanes with mask 0 SHALL have arbiter_result[i] = 0 and data 0.
REQ-009 Current lane value SHALL be, by priority: write issued at T-1 with that lane enabled (forward write_reg_11_xor register); else write issued at T-2 with that lane enabled (forward one-cycle-delayed copy); else rd_out_update lane.
REQ-010 Cycles without an issued write SHALL produce arbiter_result = 0 two cycles later; write_reg_11_xor then holds 0.
REQ-011 INIT SHALL sweep counter 0..DEPTH-1, one write per cycle: index = counter, mask all ones, in_data = 0, so every lane commits 0 through the same pipeline and forwarding.
REQ-012 INIT -> RUN the cycle after counter = DEPTH-1 is issued; INIT lasts exactly DEPTH cycles.
REQ-013 clear_req in RUN SHALL block acceptance that cycle and enter INIT with counter 0 next cycle; in-flight writes complete unchanged.
REQ-014 clear_req in INIT SHALL restart counter at 0.
REQ-015 upd_count SHALL increment once per RUN-originated write at T+2 (INIT writes excluded), wrapping modulo 2^32.
REQ-016 When idle in RUN, rd_index SHALL equal in_index (don't-care to table).

Reset
REQ-017 reset low SHALL asynchronously force: state INIT, counter 0, pipeline valids 0, arbiter_result 0, write_reg_11_xor 0, upd_count 0, in_ready 0.
REQ-018 After reset release, INIT SHALL start at the first rising edge; reset mid-operation drops in-flight writes.

Structure
REQ-019 State encoding and DEPTH derivation SHALL live in shared package xor_hash_pkg.
REQ-020 Per-lane 3-way forwarding mux plus XOR SHALL be sub-module xor_fwd_lane, instantiated NUM_MUL times.

Verification (NUM_MUL=4, INDEX_WIDTH=12)
REQ-021 Reset release -> in_ready 0 for 4096 cycles, 4096 writes with arbiter_result 4'hF and data 0, then in_ready 1.
REQ-022 Accept index 5, mask 4'b0001, lane0 64'hA5 -> two cycles later arbiter_result 4'b0001, lane0 64'hA5, upd_count 1.
REQ-023 Back-to-back index 7, mask 4'hF, data 64'h1 then 64'h2 -> second write 64'h3 all lanes (distance-1 forward).
REQ-024 Index 9 mask 4'b0011 data 64'hF0, idle, index 9 mask 4'b0110 data 64'h0F -> lane1 64'hFF, lane2 64'h0F (distance-2 forward plus memory).
REQ-025 clear_req during streaming -> in_ready drops same cycle, pending writes commit, 4096 zero writes, then read of index 5 returns 0.
REQ-026 reset asserted mid-INIT -> outputs zero immediately; full 4096-cycle INIT restarts.
